// File: rtl/tap_line_pkg.sv
// Shared constants and helpers for the stream tap line.
package tap_line_pkg;

    // Values accepted by the EMIT_PRIMED parameter of stream_tap_line
    localparam int unsigned EmitAlways = 0;  // snapshot after every accepted sample
    localparam int unsigned EmitPrimed = 1;  // snapshot only once every tap holds a sample

    // Bits needed to count from 0 up to and including depth
    function automatic int unsigned fill_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tap_fill_counter.sv
// Saturating up-counter tracking how many taps hold real samples.
// Clear has priority over increment.
module tap_fill_counter
    import tap_line_pkg::*;
#(
    parameter int unsigned MaxCount = 32,
    parameter int unsigned CntW     = fill_w(MaxCount)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [CntW-1:0] count_o,
    output logic            full_o
);

    localparam logic [CntW-1:0] MaxVal = CntW'(MaxCount);

    logic [CntW-1:0] count_d, count_q;

    // Next count: clear, saturating increment, or hold
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != MaxVal)) begin
            count_d = count_q + CntW'(1);
        end
    end

    // Count register, cleared asynchronously by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    // Decoded straight from the register so it carries no extra latency
    assign full_o  = (count_q == MaxVal);

endmodule

// File: rtl/stream_tap_line.sv
// Streaming tap delay line: each accepted sample shifts into tap 0 and the
// whole tap vector is offered downstream as one snapshot on a valid/ready pair.
module stream_tap_line
    import tap_line_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned EMIT_PRIMED = EmitAlways
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [WIDTH-1:0]              s_data,
    input  logic                          flush,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DEPTH-1:0][WIDTH-1:0]   m_taps,
    output logic [fill_w(DEPTH)-1:0]      fill_count,
    output logic                          primed
);

    localparam int unsigned     CntW     = fill_w(DEPTH);
    // Fill level at which one more accept completes the line
    localparam logic [CntW-1:0] LastFree = CntW'(DEPTH - 1);

    logic                        accept;
    logic                        fills_line;
    logic [DEPTH-1:0][WIDTH-1:0] taps_d, taps_q;
    logic                        m_valid_d, m_valid_q;

    // A new sample may enter whenever the current snapshot is gone or leaving now
    assign s_ready    = (!m_valid_q || m_ready) && !flush;
    assign accept     = s_valid && s_ready && !flush;
    // True when the line is full after this accept (already full, or one short)
    assign fills_line = (fill_count >= LastFree);

    // Tap shift: newest sample lands in tap 0, oldest tap falls off the end
    always_comb begin
        taps_d = taps_q;
        if (flush) begin
            taps_d = '0;
        end else if (accept) begin
            taps_d = {taps_q[DEPTH-2:0], s_data};
        end
    end

    // Snapshot valid: set by accept, dropped when consumed without a refill
    always_comb begin
        m_valid_d = m_valid_q;
        if (flush) begin
            m_valid_d = 1'b0;
        end else if (accept) begin
            m_valid_d = (EMIT_PRIMED == EmitAlways) ? 1'b1 : fills_line;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // Tap storage and valid flag, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            taps_q    <= '0;
            m_valid_q <= 1'b0;
        end else begin
            taps_q    <= taps_d;
            m_valid_q <= m_valid_d;
        end
    end

    tap_fill_counter #(
        .MaxCount (DEPTH),
        .CntW     (CntW)
    ) u_fill (
        .clk_i   (clk),
        .rst_ni  (rstn),
        .clr_i   (flush),
        .inc_i   (accept),
        .count_o (fill_count),
        .full_o  (primed)
    );

    assign m_taps  = taps_q;
    assign m_valid = m_valid_q;

endmodule

// File: tb/tb_stream_tap_line.sv
// Directed and randomised checks of stream_tap_line with WIDTH=8, DEPTH=4.
// dut0 emits after every accept, dut1 only once the line is full.
module tb_stream_tap_line;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic               s_valid0, s_ready0, flush0, m_valid0, m_ready0, primed0;
    logic [W-1:0]       s_data0;
    logic [D-1:0][W-1:0] m_taps0;
    logic [2:0]         fill0;

    logic               s_valid1, s_ready1, flush1, m_valid1, m_ready1, primed1;
    logic [W-1:0]       s_data1;
    logic [D-1:0][W-1:0] m_taps1;
    logic [2:0]         fill1;

    int checks   = 0;
    int failures = 0;

    stream_tap_line #(
        .WIDTH       (W),
        .DEPTH       (D),
        .EMIT_PRIMED (0)
    ) dut0 (
        .clk        (clk),
        .rstn       (rstn),
        .s_valid    (s_valid0),
        .s_ready    (s_ready0),
        .s_data     (s_data0),
        .flush      (flush0),
        .m_valid    (m_valid0),
        .m_ready    (m_ready0),
        .m_taps     (m_taps0),
        .fill_count (fill0),
        .primed     (primed0)
    );

    stream_tap_line #(
        .WIDTH       (W),
        .DEPTH       (D),
        .EMIT_PRIMED (1)
    ) dut1 (
        .clk        (clk),
        .rstn       (rstn),
        .s_valid    (s_valid1),
        .s_ready    (s_ready1),
        .s_data     (s_data1),
        .flush      (flush1),
        .m_valid    (m_valid1),
        .m_ready    (m_ready1),
        .m_taps     (m_taps1),
        .fill_count (fill1),
        .primed     (primed1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #2;
        checks++; if (m_taps0 !== '0) begin failures++;
            $display("FAIL reset_taps0 got=%h exp=0", m_taps0); end
        checks++; if (fill0 !== 3'd0) begin failures++;
            $display("FAIL reset_fill0 got=%0d exp=0", fill0); end
        checks++; if (m_valid0 !== 1'b0) begin failures++;
            $display("FAIL reset_mvalid0 got=%b exp=0", m_valid0); end
        checks++; if (primed0 !== 1'b0) begin failures++;
            $display("FAIL reset_primed0 got=%b exp=0", primed0); end
        checks++; if (s_ready0 !== 1'b1) begin failures++;
            $display("FAIL reset_sready0 got=%b exp=1", s_ready0); end
        checks++; if (m_taps1 !== '0 || m_valid1 !== 1'b0 || fill1 !== 3'd0) begin failures++;
            $display("FAIL reset_dut1 got taps=%h valid=%b fill=%0d exp 0/0/0",
                     m_taps1, m_valid1, fill1); end
        step();
        checks++; if (s_ready1 !== 1'b1) begin failures++;
            $display("FAIL reset_sready1 got=%b exp=1", s_ready1); end
        @(negedge clk);
        rstn = 1'b1;
        step();
        checks++; if (s_ready0 !== 1'b1 || m_valid0 !== 1'b0 || fill0 !== 3'd0) begin
            failures++;
            $display("FAIL post_reset got ready=%b valid=%b fill=%0d exp 1/0/0",
                     s_ready0, m_valid0, fill0); end
    endtask

    task automatic test_fill_stream();
        logic [2:0] ef;
        m_ready0 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            s_valid0 = 1'b1;
            s_data0  = W'(k);
            checks++; if (s_ready0 !== 1'b1) begin failures++;
                $display("FAIL stream_sready k=%0d got=%b exp=1", k, s_ready0); end
            step();
            ef = (k < 4) ? 3'(k) : 3'd4;
            checks++; if (m_valid0 !== 1'b1) begin failures++;
                $display("FAIL stream_mvalid k=%0d got=%b exp=1", k, m_valid0); end
            checks++; if (m_taps0[0] !== W'(k)) begin failures++;
                $display("FAIL stream_tap0 k=%0d got=%h exp=%h", k, m_taps0[0], W'(k)); end
            checks++; if (fill0 !== ef) begin failures++;
                $display("FAIL stream_fill k=%0d got=%0d exp=%0d", k, fill0, ef); end
        end
        checks++; if (m_taps0 !== 32'h02030405) begin failures++;
            $display("FAIL stream_taps got=%h exp=02030405", m_taps0); end
        checks++; if (primed0 !== 1'b1) begin failures++;
            $display("FAIL stream_primed got=%b exp=1", primed0); end
        s_valid0 = 1'b0;
        step();
        checks++; if (m_valid0 !== 1'b0 || m_taps0 !== 32'h02030405) begin failures++;
            $display("FAIL stream_drain got valid=%b taps=%h exp 0/02030405",
                     m_valid0, m_taps0); end
    endtask

    task automatic test_emit_primed();
        m_ready1 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            s_valid1 = 1'b1;
            s_data1  = W'(k);
            step();
            checks++; if (m_valid1 !== 1'b0 || fill1 !== 3'(k)) begin failures++;
                $display("FAIL primed_early k=%0d got valid=%b fill=%0d exp 0/%0d",
                         k, m_valid1, fill1, k); end
        end
        s_data1 = 8'd4;
        step();
        checks++; if (m_valid1 !== 1'b1) begin failures++;
            $display("FAIL primed_valid got=%b exp=1", m_valid1); end
        checks++; if (m_taps1 !== 32'h01020304) begin failures++;
            $display("FAIL primed_taps got=%h exp=01020304", m_taps1); end
        checks++; if (primed1 !== 1'b1) begin failures++;
            $display("FAIL primed_flag got=%b exp=1", primed1); end
        s_data1 = 8'd5;
        step();
        checks++; if (m_valid1 !== 1'b1 || m_taps1 !== 32'h02030405) begin failures++;
            $display("FAIL primed_next got valid=%b taps=%h exp 1/02030405",
                     m_valid1, m_taps1); end
        s_valid1 = 1'b0;
        step();
        checks++; if (m_valid1 !== 1'b0) begin failures++;
            $display("FAIL primed_drain got=%b exp=0", m_valid1); end
    endtask

    task automatic test_backpressure();
        m_ready0 = 1'b0;
        s_valid0 = 1'b1;
        s_data0  = 8'h10;
        checks++; if (s_ready0 !== 1'b1) begin failures++;
            $display("FAIL bp_idle_ready got=%b exp=1", s_ready0); end
        step();
        checks++; if (m_valid0 !== 1'b1 || m_taps0 !== 32'h03040510) begin failures++;
            $display("FAIL bp_load got valid=%b taps=%h exp 1/03040510", m_valid0, m_taps0); end
        s_data0 = 8'h11;
        for (int c = 0; c < 3; c++) begin
            checks++; if (s_ready0 !== 1'b0) begin failures++;
                $display("FAIL bp_stall_ready c=%0d got=%b exp=0", c, s_ready0); end
            step();
            checks++; if (m_valid0 !== 1'b1 || m_taps0 !== 32'h03040510) begin failures++;
                $display("FAIL bp_hold c=%0d got valid=%b taps=%h exp 1/03040510",
                         c, m_valid0, m_taps0); end
        end
        m_ready0 = 1'b1;
        #1;
        checks++; if (s_ready0 !== 1'b1) begin failures++;
            $display("FAIL bp_release_ready got=%b exp=1", s_ready0); end
        step();
        checks++; if (m_valid0 !== 1'b1 || m_taps0 !== 32'h04051011) begin failures++;
            $display("FAIL bp_resume1 got valid=%b taps=%h exp 1/04051011", m_valid0, m_taps0); end
        s_data0 = 8'h12;
        step();
        checks++; if (m_valid0 !== 1'b1 || m_taps0 !== 32'h05101112) begin failures++;
            $display("FAIL bp_resume2 got valid=%b taps=%h exp 1/05101112", m_valid0, m_taps0); end
        s_valid0 = 1'b0;
        step();
        checks++; if (m_valid0 !== 1'b0 || m_taps0 !== 32'h05101112) begin failures++;
            $display("FAIL bp_drain got valid=%b taps=%h exp 0/05101112", m_valid0, m_taps0); end
    endtask

    task automatic test_flush();
        m_ready0 = 1'b1;
        s_valid0 = 1'b1;
        s_data0  = 8'hAA;
        flush0   = 1'b1;
        #1;
        checks++; if (s_ready0 !== 1'b0) begin failures++;
            $display("FAIL flush_ready got=%b exp=0", s_ready0); end
        step();
        flush0   = 1'b0;
        checks++; if (m_taps0 !== '0 || fill0 !== 3'd0) begin failures++;
            $display("FAIL flush_clear got taps=%h fill=%0d exp 0/0", m_taps0, fill0); end
        checks++; if (m_valid0 !== 1'b0 || primed0 !== 1'b0) begin failures++;
            $display("FAIL flush_flags got valid=%b primed=%b exp 0/0", m_valid0, primed0); end
        s_data0 = 8'h01;
        step();
        checks++; if (m_taps0 !== 32'h00000001 || fill0 !== 3'd1) begin failures++;
            $display("FAIL flush_after got taps=%h fill=%0d exp 00000001/1", m_taps0, fill0); end
    endtask

    task automatic test_async_reset();
        s_valid0 = 1'b1;
        s_data0  = 8'h21;
        step();
        s_data0  = 8'h22;
        step();
        s_valid0 = 1'b0;
        checks++; if (m_taps0 !== 32'h00012122 || fill0 !== 3'd3) begin failures++;
            $display("FAIL arst_pre got taps=%h fill=%0d exp 00012122/3", m_taps0, fill0); end
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (m_taps0 !== '0 || fill0 !== 3'd0 || m_valid0 !== 1'b0 || primed0 !== 1'b0)
        begin failures++;
            $display("FAIL arst_dut0 got taps=%h fill=%0d valid=%b primed=%b exp all 0",
                     m_taps0, fill0, m_valid0, primed0); end
        checks++; if (m_taps1 !== '0 || primed1 !== 1'b0) begin failures++;
            $display("FAIL arst_dut1 got taps=%h primed=%b exp 0/0", m_taps1, primed1); end
        checks++; if (s_ready0 !== 1'b1) begin failures++;
            $display("FAIL arst_ready got=%b exp=1", s_ready0); end
        #1;
        rstn     = 1'b1;
        s_valid0 = 1'b1;
        s_data0  = 8'h11;
        m_ready0 = 1'b1;
        step();
        s_valid0 = 1'b0;
        checks++; if (m_taps0 !== 32'h00000011 || fill0 !== 3'd1 || m_valid0 !== 1'b1) begin
            failures++;
            $display("FAIL arst_first got taps=%h fill=%0d valid=%b exp 00000011/1/1",
                     m_taps0, fill0, m_valid0); end
    endtask

    task automatic test_random();
        logic [W-1:0]        q[$];
        logic                mv;
        logic                sv, mr, fl, er;
        logic [W-1:0]        d;
        logic [D-1:0][W-1:0] exp_taps;
        flush0 = 1'b1;
        s_valid0 = 1'b0;
        step();
        flush0 = 1'b0;
        mv = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            sv = ($urandom_range(0, 3) != 0);
            mr = ($urandom_range(0, 1) != 0);
            fl = ($urandom_range(0, 63) == 0);
            d  = W'($urandom_range(0, 255));
            s_valid0 = sv;
            m_ready0 = mr;
            flush0   = fl;
            s_data0  = d;
            er = (!mv || mr) && !fl;
            #1;
            checks++; if (s_ready0 !== er) begin failures++;
                $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, s_ready0, er); end
            if (fl) begin
                q.delete();
                mv = 1'b0;
            end else if (sv && er) begin
                q.push_front(d);
                if (q.size() > D) void'(q.pop_back());
                mv = 1'b1;
            end else if (mr) begin
                mv = 1'b0;
            end
            step();
            checks++; if (m_valid0 !== mv) begin failures++;
                $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, m_valid0, mv); end
            checks++; if (fill0 !== 3'(q.size())) begin failures++;
                $display("FAIL rnd_fill n=%0d got=%0d exp=%0d", n, fill0, q.size()); end
            checks++; if (fill0 > 3'd4) begin failures++;
                $display("FAIL rnd_fill_bound n=%0d got=%0d exp<=4", n, fill0); end
            if (mv) begin
                for (int i = 0; i < D; i++) begin
                    exp_taps[i] = (i < q.size()) ? q[i] : '0;
                end
                checks++; if (m_taps0 !== exp_taps) begin failures++;
                    $display("FAIL rnd_taps n=%0d got=%h exp=%h", n, m_taps0, exp_taps); end
            end
        end
        s_valid0 = 1'b0;
        flush0   = 1'b0;
        m_ready0 = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        s_valid0 = 1'b0; s_data0 = '0; flush0 = 1'b0; m_ready0 = 1'b1;
        s_valid1 = 1'b0; s_data1 = '0; flush1 = 1'b0; m_ready1 = 1'b1;
        test_reset();
        test_fill_stream();
        test_emit_primed();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_tap_line.md
STREAM_TAP_LINE -- requirements
Module: stream_tap_line

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 32, number of taps (>=2).
REQ-003 SHALL have parameter EMIT_PRIMED, default 0; 1 = suppress m_valid until the line is full.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port s_valid  input  1  input sample valid.
REQ-007 SHALL have port s_ready  output  1  block can accept an input sample.
REQ-008 SHALL have port s_data  input  WIDTH  input sample.
REQ-009 SHALL have port flush  input  1  synchronous clear of line contents.
REQ-010 SHALL have port m_valid  output  1  tap snapshot valid.
REQ-011 SHALL have port m_ready  input  1  downstream accepts the snapshot.
REQ-012 SHALL have port m_taps  output  DEPTH x WIDTH (packed)  tap vector; index 0 = newest.
REQ-013 SHALL have port fill_count  output  $clog2(DEPTH+1)  number of valid taps, saturating.
REQ-014 SHALL have port primed  output  1  high when fill_count == DEPTH.

Function
REQ-015 SHALL define accept = s_valid && s_ready && !flush.
REQ-016 SHALL drive s_ready = (!m_valid || m_ready) && !flush, combinationally.
REQ-017 On accept, SHALL load m_taps[0] <= s_data and m_taps[i] <= m_taps[i-1] for 1<=i<DEPTH; the oldest sample is discarded; no out-of-range index is ever read.
REQ-018 Without accept, SHALL hold m_taps unchanged.
REQ-019 On accept, SHALL increment fill_count by 1, saturating at DEPTH.
REQ-020 With EMIT_PRIMED=0, SHALL set m_valid the cycle after every accept.
REQ-021 With EMIT_PRIMED=1, SHALL set m_valid after an accept only if the post-accept fill_count equals DEPTH.
REQ-022 SHALL clear m_valid on m_valid && m_ready when there is no accept in the same cycle; accept plus m_ready in one cycle SHALL leave m_valid set, with the new snapshot (zero-bubble throughput, 1 sample/cycle).
REQ-023 SHALL keep m_taps stable while m_valid && !m_ready.
REQ-024 Flush SHALL take priority over s_valid/m_ready: the next cycle, m_taps = 0, fill_count = 0, m_valid = 0; a sample presented during flush is not accepted.
REQ-025 SHALL have latency of one clock from accept to the snapshot containing that sample on m_taps.
REQ-026 primed SHALL be registered-equivalent, i.e. decoded from fill_count with no extra delay.

Reset
REQ-027 While rstn is low, SHALL force m_taps = 0, fill_count = 0, m_valid = 0, primed = 0, asynchronously.
REQ-028 s_ready SHALL be 1 during and after reset when flush = 0.
REQ-029 Reset asserted mid-stream SHALL discard all samples; the first accept after reset SHALL yield fill_count = 1.

Structure
REQ-030 Package tap_line_pkg SHALL hold the fill-count width function (clog2(DEPTH+1)) and the EMIT_PRIMED mode constants.
REQ-031 Sub-module tap_fill_counter (saturating up-counter with synchronous clear and async reset) SHALL implement fill_count.
REQ-032 Tap storage SHALL be a plain shift register; no RAM inference.

Verification (WIDTH=8, DEPTH=4)
REQ-033 EMIT_PRIMED=0, m_ready=1, feed 1,2,3,4,5 on consecutive cycles -> after the 5th accept m_taps = {2,3,4,5} (index 3..0), fill_count = 4, primed = 1, m_valid high every cycle after the first accept.
REQ-034 EMIT_PRIMED=1, feed 1,2,3 -> m_valid stays 0; feed 4 -> next cycle m_valid = 1, m_taps = {1,2,3,4}.
REQ-035 Backpressure: m_ready=0 with m_valid=1, s_valid=1 -> s_ready = 0, m_taps held for 3 cycles; raise m_ready -> exactly one accept per cycle resumes, no sample lost or duplicated.
REQ-036 Flush asserted together with s_valid=1, s_data=0xAA and m_ready=1 -> next cycle m_taps = 0, fill_count = 0, m_valid = 0; 0xAA is absent from the line.
REQ-037 rstn pulsed low between clock edges mid-stream -> outputs are zero immediately; the next accept of 0x11 gives m_taps[0] = 0x11, other taps 0, fill_count = 1.
REQ-038 Random s_valid/m_ready for 10k cycles against a reference queue model -> every accepted snapshot matches the model; fill_count never exceeds 4.
